eei_issue_ctrl: RTL and testbench

- Core-side controller that drives the EEI request interface of the custom execution unit and consumes its response.
- Accepts one decoded custom instruction at a time and holds the EEI request fields stable until ack.
- Bounds the wait with a timeout.
- Serialises single or batch rd results onto the integer register file's single write port, then reports completion to the pipeline.

---
 rtl/eei_pkg.sv | 35 +++
 rtl/eei_wb_seq.sv | 48 ++++
 rtl/eei_issue_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_eei_issue_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/eei_pkg.sv
// Shared types and constants for the EEI issue controller.
// Imported by the controller top and its write-back sequencer.
package eei_pkg;

   localparam int F3_W    = 3;
   localparam int F7_W    = 7;
   localparam int LEN_W   = 5;
   localparam int REG_W   = 5;
   localparam int OP_W    = 2;
   localparam int CAUSE_W = 2;
   localparam int WAIT_W  = 16;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WB   = 2'd2,
      S_RESP = 2'd3
   } state_t;

   localparam logic [OP_W-1:0] RDOP_NONE      = 2'd0;
   localparam logic [OP_W-1:0] RDOP_SINGLE    = 2'd1;
   localparam logic [OP_W-1:0] RDOP_BATCH     = 2'd2;
   localparam logic [OP_W-1:0] RDOP_BATCH_EXT = 2'd3;

   localparam logic [CAUSE_W-1:0] CAUSE_OK      = 2'd0;
   localparam logic [CAUSE_W-1:0] CAUSE_ERR     = 2'd1;
   localparam logic [CAUSE_W-1:0] CAUSE_TIMEOUT = 2'd2;
   localparam logic [CAUSE_W-1:0] CAUSE_CLAMP   = 2'd3;

   // Both batch encodings share the upper op bit.
   function automatic logic is_batch(input logic [OP_W-1:0] op);
      return op[1];
   endfunction

endpackage

// File: rtl/eei_wb_seq.sv
// Write-back sequencer: walks latched result lanes onto the
// single register-file write port, one lane per cycle.
module eei_wb_seq
   import eei_pkg::*;
#(
   parameter int RD_MAX = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 run,
   input  logic                 single,
   input  logic [REG_W-1:0]     base,
   input  logic [LEN_W-1:0]     count,
   input  logic [RD_MAX*32-1:0] lanes,
   output logic                 rf_we,
   output logic [REG_W-1:0]     rf_waddr,
   output logic [31:0]          rf_wdata,
   output logic                 last
);

   logic [LEN_W-1:0] idx_q;

   // Lane index: cleared when a write-back is launched, steps per write cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx_q <= '0;
      end else if (start) begin
         idx_q <= '0;
      end else if (run && !last) begin
         idx_q <= idx_q + 1'b1;
      end
   end

   // Address/data generation; x0 consumes its slot but never writes.
   always_comb begin
      rf_wdata = '0;
      for (int i = 0; i < RD_MAX; i++) begin
         if (idx_q == LEN_W'(i)) begin
            rf_wdata = lanes[i*32 +: 32];
         end
      end
      rf_waddr = single ? base : base + REG_W'(idx_q);
      last     = run && (idx_q == count - 1'b1);
      rf_we    = run && (rf_waddr != '0);
   end

endmodule

// File: rtl/eei_issue_ctrl.sv
// EEI issue controller: drives the custom-unit request, bounds the
// wait, serialises rd results and pulses completion.
module eei_issue_ctrl
   import eei_pkg::*;
#(
   parameter int RD_MAX  = 8,
   parameter int TIMEOUT = 255
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 issue_valid,
   output logic                 issue_ready,
   input  logic                 issue_ext,
   input  logic [F3_W-1:0]      issue_funct3,
   input  logic [F7_W-1:0]      issue_funct7,
   input  logic [REG_W-1:0]     issue_rd,
   input  logic [REG_W-1:0]     issue_batch_start,
   input  logic [LEN_W-1:0]     issue_batch_len,
   output logic                 eei_req,
   output logic                 eei_ext,
   output logic [F3_W-1:0]      eei_funct3,
   output logic [F7_W-1:0]      eei_funct7,
   output logic [REG_W-1:0]     eei_batch_start,
   output logic [LEN_W-1:0]     eei_batch_len,
   input  logic                 eei_ack,
   input  logic                 eei_error,
   input  logic [OP_W-1:0]      eei_rd_op,
   input  logic [LEN_W-1:0]     eei_rd_len,
   input  logic [RD_MAX*32-1:0] eei_rd_val,
   output logic                 rf_we,
   output logic [REG_W-1:0]     rf_waddr,
   output logic [31:0]          rf_wdata,
   output logic                 done_valid,
   output logic [CAUSE_W-1:0]   done_cause,
   output logic                 busy
);

   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
   localparam logic [LEN_W-1:0]  LEN_MAX   = LEN_W'(RD_MAX);

   state_t                state_q, state_d;
   logic [CAUSE_W-1:0]    cause_q, cause_d;
   logic [WAIT_W-1:0]     wait_q;
   logic                  ext_q;
   logic [F3_W-1:0]       f3_q;
   logic [F7_W-1:0]       f7_q;
   logic [REG_W-1:0]      rd_q;
   logic [REG_W-1:0]      bstart_q;
   logic [LEN_W-1:0]      blen_q;
   logic [RD_MAX*32-1:0]  lanes_q;
   logic [LEN_W-1:0]      count_q;
   logic                  single_q;
   logic                  wb_start;
   logic                  wb_last;
   logic                  batch;
   logic                  clamp;

   assign batch = is_batch(eei_rd_op);
   assign clamp = batch && (eei_rd_len > LEN_MAX);

   // Next-state and completion-cause selection.
   always_comb begin
      state_d  = state_q;
      cause_d  = cause_q;
      wb_start = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (issue_valid) begin
               state_d = S_REQ;
               cause_d = CAUSE_OK;
            end
         end
         S_REQ: begin
            if (eei_ack) begin
               if (eei_error) begin
                  state_d = S_RESP;
                  cause_d = CAUSE_ERR;
               end else if (eei_rd_op == RDOP_NONE) begin
                  state_d = S_RESP;
                  cause_d = CAUSE_OK;
               end else if (batch && eei_rd_len == '0) begin
                  state_d = S_RESP;
                  cause_d = CAUSE_OK;
               end else begin
                  state_d  = S_WB;
                  wb_start = 1'b1;
                  cause_d  = clamp ? CAUSE_CLAMP : CAUSE_OK;
               end
            end else if (wait_q == WAIT_LAST) begin
               state_d = S_RESP;
               cause_d = CAUSE_TIMEOUT;
            end
         end
         S_WB: begin
            if (wb_last) begin
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, capture registers, wait counter and response latches.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q  <= S_IDLE;
         cause_q  <= CAUSE_OK;
         wait_q   <= '0;
         ext_q    <= 1'b0;
         f3_q     <= '0;
         f7_q     <= '0;
         rd_q     <= '0;
         bstart_q <= '0;
         blen_q   <= '0;
         lanes_q  <= '0;
         count_q  <= '0;
         single_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
         if (state_q == S_IDLE && issue_valid) begin
            ext_q    <= issue_ext;
            f3_q     <= issue_funct3;
            f7_q     <= issue_funct7;
            rd_q     <= issue_rd;
            bstart_q <= issue_batch_start;
            blen_q   <= issue_batch_len;
            wait_q   <= '0;
         end
         if (state_q == S_REQ) begin
            wait_q <= wait_q + 1'b1;
            if (eei_ack) begin
               lanes_q  <= eei_rd_val;
               single_q <= !batch;
               if (!batch) begin
                  count_q <= LEN_W'(1);
               end else if (clamp) begin
                  count_q <= LEN_MAX;
               end else begin
                  count_q <= eei_rd_len;
               end
            end
         end
      end
   end

   eei_wb_seq #(
      .RD_MAX (RD_MAX)
   ) u_wb_seq (
      .clk      (clk_i),
      .rst_n    (rst_ni),
      .start    (wb_start),
      .run      (state_q == S_WB),
      .single   (single_q),
      .base     (single_q ? rd_q : bstart_q),
      .count    (count_q),
      .lanes    (lanes_q),
      .rf_we    (rf_we),
      .rf_waddr (rf_waddr),
      .rf_wdata (rf_wdata),
      .last     (wb_last)
   );

   assign issue_ready     = (state_q == S_IDLE);
   assign busy            = (state_q != S_IDLE);
   assign eei_req         = (state_q == S_REQ);
   assign eei_ext         = ext_q;
   assign eei_funct3      = f3_q;
   assign eei_funct7      = f7_q;
   assign eei_batch_start = bstart_q;
   assign eei_batch_len   = blen_q;
   assign done_valid      = (state_q == S_RESP);
   assign done_cause      = done_valid ? cause_q : CAUSE_OK;

endmodule

// File: tb/tb_eei_issue_ctrl.sv
// Directed bench for eei_issue_ctrl: vector table of transactions
// plus a hand-written reset-during-write-back sequence.
module tb_eei_issue_ctrl;

   localparam int RD_MAX = 8;
   localparam int TMO    = 4;

   logic                 clk = 1'b0;
   logic                 rst_ni = 1'b0;
   logic                 issue_valid = 1'b0;
   logic                 issue_ready;
   logic                 issue_ext = 1'b0;
   logic [2:0]           issue_funct3 = '0;
   logic [6:0]           issue_funct7 = '0;
   logic [4:0]           issue_rd = '0;
   logic [4:0]           issue_batch_start = '0;
   logic [4:0]           issue_batch_len = '0;
   logic                 eei_req;
   logic                 eei_ext;
   logic [2:0]           eei_funct3;
   logic [6:0]           eei_funct7;
   logic [4:0]           eei_batch_start;
   logic [4:0]           eei_batch_len;
   logic                 eei_ack = 1'b0;
   logic                 eei_error = 1'b0;
   logic [1:0]           eei_rd_op = '0;
   logic [4:0]           eei_rd_len = '0;
   logic [RD_MAX*32-1:0] eei_rd_val = '0;
   logic                 rf_we;
   logic [4:0]           rf_waddr;
   logic [31:0]          rf_wdata;
   logic                 done_valid;
   logic [1:0]           done_cause;
   logic                 busy;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   eei_issue_ctrl #(
      .RD_MAX  (RD_MAX),
      .TIMEOUT (TMO)
   ) dut (
      .clk_i             (clk),
      .rst_ni            (rst_ni),
      .issue_valid       (issue_valid),
      .issue_ready       (issue_ready),
      .issue_ext         (issue_ext),
      .issue_funct3      (issue_funct3),
      .issue_funct7      (issue_funct7),
      .issue_rd          (issue_rd),
      .issue_batch_start (issue_batch_start),
      .issue_batch_len   (issue_batch_len),
      .eei_req           (eei_req),
      .eei_ext           (eei_ext),
      .eei_funct3        (eei_funct3),
      .eei_funct7        (eei_funct7),
      .eei_batch_start   (eei_batch_start),
      .eei_batch_len     (eei_batch_len),
      .eei_ack           (eei_ack),
      .eei_error         (eei_error),
      .eei_rd_op         (eei_rd_op),
      .eei_rd_len        (eei_rd_len),
      .eei_rd_val        (eei_rd_val),
      .rf_we             (rf_we),
      .rf_waddr          (rf_waddr),
      .rf_wdata          (rf_wdata),
      .done_valid        (done_valid),
      .done_cause        (done_cause),
      .busy              (busy)
   );

   typedef struct {
      logic            ext;
      logic [4:0]      rd;
      logic [4:0]      bs;
      logic [4:0]      bl;
      logic [2:0]      f3;
      logic [6:0]      f7;
      logic [1:0]      op;
      logic [4:0]      rd_len;
      logic            err;
      int              ack_at;
      logic [31:0]     lane0;
      int              n_wr;
      logic [7:0][4:0] wa;
      logic [7:0][2:0] wl;
      int              req_last;
      int              done_at;
      logic [1:0]      cause;
   } vec_t;

   localparam int NV = 11;
   vec_t vt[NV];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] lane(input int i, input logic [31:0] l0);
      return (i == 0) ? l0 : 32'h11 * (i + 1);
   endfunction

   function automatic logic [RD_MAX*32-1:0] lanes(input logic [31:0] l0);
      logic [RD_MAX*32-1:0] r;
      r = '0;
      for (int i = 0; i < RD_MAX; i++) r[i*32 +: 32] = lane(i, l0);
      return r;
   endfunction

   task automatic run_vec(input int vi);
      vec_t        v;
      int          k;
      int          dn;
      int          dc;
      int          rq_bad;
      logic [1:0]  cs;
      logic [31:0] exp_d;
      v = vt[vi];
      k = 0; dn = 0; dc = -1; rq_bad = 0; cs = '0;
      @(negedge clk);
      issue_ext = v.ext; issue_rd = v.rd;
      issue_batch_start = v.bs; issue_batch_len = v.bl;
      issue_funct3 = v.f3; issue_funct7 = v.f7;
      issue_valid = 1'b1;
      chk($sformatf("v%0d_ready0", vi), 64'(issue_ready), 64'd1);
      @(posedge clk);
      for (int c = 1; c <= 14; c++) begin
         #1;
         issue_valid = (c == 1);
         eei_ack     = (c == v.ack_at);
         eei_error   = v.err;
         eei_rd_op   = v.op;
         eei_rd_len  = v.rd_len;
         eei_rd_val  = (c == v.ack_at) ? lanes(v.lane0) : ~lanes(v.lane0);
         @(negedge clk);
         if (c == 1) begin
            chk($sformatf("v%0d_fields", vi),
                64'({eei_ext, eei_funct3, eei_funct7, eei_batch_start, eei_batch_len}),
                64'({v.ext, v.f3, v.f7, v.bs, v.bl}));
            chk($sformatf("v%0d_ready1", vi), 64'({issue_ready, busy}), 64'b01);
         end
         if (eei_req !== (c <= v.req_last)) rq_bad++;
         if (rf_we === 1'b1) begin
            if (k < 8) begin
               exp_d = lane(int'(v.wl[k]), v.lane0);
               chk($sformatf("v%0d_w%0d_addr", vi, k), 64'(rf_waddr), 64'(v.wa[k]));
               chk($sformatf("v%0d_w%0d_data", vi, k), 64'(rf_wdata), 64'(exp_d));
            end
            k++;
         end
         if (done_valid === 1'b1) begin
            dn++; dc = c; cs = done_cause;
         end
         @(posedge clk);
      end
      #1 eei_ack = 1'b0;
      chk($sformatf("v%0d_req_window", vi), 64'(rq_bad), 64'd0);
      chk($sformatf("v%0d_nwrites", vi), 64'(k), 64'(v.n_wr));
      chk($sformatf("v%0d_done_cnt", vi), 64'(dn), 64'd1);
      chk($sformatf("v%0d_done_cyc", vi), 64'(dc), 64'(v.done_at));
      chk($sformatf("v%0d_cause", vi), 64'(cs), 64'(v.cause));
   endtask

   task automatic reset_mid_batch();
      int bad;
      bad = 0;
      @(negedge clk);
      issue_ext = 1'b1; issue_batch_start = 5'd10; issue_batch_len = 5'd4;
      issue_valid = 1'b1;
      @(posedge clk);
      #1;
      issue_valid = 1'b0;
      eei_ack = 1'b1; eei_error = 1'b0; eei_rd_op = 2'd2; eei_rd_len = 5'd4;
      eei_rd_val = lanes(32'h5A5A_0001);
      @(posedge clk);
      #1 eei_ack = 1'b0;
      @(negedge clk);
      chk("rst_wb0", 64'({rf_we, rf_waddr}), 64'({1'b1, 5'd10}));
      @(posedge clk);
      #1 rst_ni = 1'b0;
      @(negedge clk);
      chk("rst_wb1", 64'({rf_we, rf_waddr, rf_wdata}), 64'({1'b1, 5'd11, 32'h22}));
      @(posedge clk);
      #1 rst_ni = 1'b1;
      @(negedge clk);
      chk("rst_after", 64'({issue_ready, busy, eei_req}), 64'b100);
      for (int c = 0; c < 6; c++) begin
         if (rf_we !== 1'b0 || done_valid !== 1'b0) bad++;
         @(negedge clk);
      end
      chk("rst_quiet", 64'(bad), 64'd0);
   endtask

   initial begin
      vt[0]  = '{1'b0, 5'd5, 5'd0, 5'd0, 3'd1, 7'h0B, 2'd1, 5'd0, 1'b0, 1,
                 32'hDEADBEEF, 1, {5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd5},
                 24'd0, 1, 3, 2'd0};
      vt[1]  = '{1'b1, 5'd0, 5'd10, 5'd3, 3'd2, 7'h2A, 2'd3, 5'd3, 1'b0, 1,
                 32'h11, 3, {5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd12, 5'd11, 5'd10},
                 {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd1, 3'd0}, 1, 5, 2'd0};
      vt[2]  = '{1'b1, 5'd0, 5'd30, 5'd4, 3'd3, 7'h15, 2'd2, 5'd4, 1'b0, 1,
                 32'h11, 3, {5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd1, 5'd31, 5'd30},
                 {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd3, 3'd1, 3'd0}, 1, 6, 2'd0};
      vt[3]  = '{1'b0, 5'd9, 5'd0, 5'd0, 3'd4, 7'h7F, 2'd1, 5'd0, 1'b0, -1,
                 32'h1, 0, 40'd0, 24'd0, 4, 5, 2'd2};
      vt[4]  = '{1'b0, 5'd7, 5'd0, 5'd0, 3'd5, 7'h01, 2'd1, 5'd0, 1'b0, 4,
                 32'hCAFEF00D, 1, {5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd7},
                 24'd0, 4, 6, 2'd0};
      vt[5]  = '{1'b1, 5'd0, 5'd4, 5'd3, 3'd6, 7'h10, 2'd2, 5'd3, 1'b1, 1,
                 32'h1, 0, 40'd0, 24'd0, 1, 2, 2'd1};
      vt[6]  = '{1'b1, 5'd0, 5'd2, 5'd12, 3'd7, 7'h40, 2'd3, 5'd12, 1'b0, 1,
                 32'h11, 8, {5'd9, 5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2},
                 {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 1, 10, 2'd3};
      vt[7]  = '{1'b0, 5'd3, 5'd0, 5'd0, 3'd0, 7'h33, 2'd0, 5'd0, 1'b0, 1,
                 32'h1, 0, 40'd0, 24'd0, 1, 2, 2'd0};
      vt[8]  = '{1'b1, 5'd0, 5'd5, 5'd0, 3'd1, 7'h22, 2'd2, 5'd0, 1'b0, 1,
                 32'h1, 0, 40'd0, 24'd0, 1, 2, 2'd0};
      vt[9]  = '{1'b0, 5'd0, 5'd0, 5'd0, 3'd2, 7'h44, 2'd1, 5'd0, 1'b0, 2,
                 32'h77, 0, 40'd0, 24'd0, 2, 4, 2'd0};
      vt[10] = '{1'b1, 5'd0, 5'd20, 5'd8, 3'd3, 7'h55, 2'd2, 5'd8, 1'b0, 1,
                 32'h11, 8, {5'd27, 5'd26, 5'd25, 5'd24, 5'd23, 5'd22, 5'd21, 5'd20},
                 {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 1, 10, 2'd0};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_state",
          64'({issue_ready, busy, eei_req, rf_we, done_valid, eei_funct3, eei_batch_len}),
          64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0}));
      rst_ni = 1'b1;
      @(negedge clk);

      for (int i = 0; i < NV; i++) run_vec(i);

      reset_mid_batch();
      run_vec(0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
